up_down_counter: RTL and testbench

- Synchronous, parameterised binary up/down counter with a count-enable input.
- Registered count output. Used as a general-purpose sequencing/position counter inside control datapaths.
- Counts modulo 2^WIDTH by default. A parameter selects saturating behaviour instead.

---
 rtl/up_down_counter_pkg.sv | 29 ++
 rtl/up_down_counter.sv | 62 ++++++
 tb/tb_up_down_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared counter definitions: default width, a reusable count type and the
// per-edge step decode used by up/down counters in this codebase.
package up_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

  // What the counter does on a given edge once reset has been ruled out.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DOWN = 2'b10
  } step_e;

  // Enable gates everything; direction only matters while enabled.
  function automatic step_e decode_step(input logic enable, input logic upcount);
    step_e step;
    if (!enable) begin
      step = STEP_HOLD;
    end else if (upcount) begin
      step = STEP_UP;
    end else begin
      step = STEP_DOWN;
    end
    return step;
  endfunction

endpackage

// File: rtl/up_down_counter.sv
// Parameterised up/down counter with count enable. Wraps modulo 2^WIDTH by
// default, or pins at all-ones / zero when SATURATE is set. The output is
// the count register itself, so nothing on the inputs reaches out without
// passing through a clock edge.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             upcount,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [WIDTH-1:0] MIN_COUNT = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  step_e            step;

  // Classify this cycle's inputs into hold / up / down.
  always_comb begin
    step = decode_step(enable, upcount);
  end

  // Next count: plain modular step, except at the limits in saturate mode.
  always_comb begin
    cnt_next = cnt;
    case (step)
      STEP_UP: begin
        if (!(SATURATE && (cnt == MAX_COUNT))) begin
          cnt_next = cnt + ONE;
        end
      end
      STEP_DOWN: begin
        if (!(SATURATE && (cnt == MIN_COUNT))) begin
          cnt_next = cnt - ONE;
        end
      end
      default: begin
        cnt_next = cnt;
      end
    endcase
  end

  // Count register; reset (active-high despite the port name) beats all else.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign out = cnt;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter. A wrap-mode and a saturate-mode
// instance share one set of inputs; each is compared after every edge with
// an integer reference model derived from the counting rules.
module tb_up_down_counter;

  localparam int W     = 4;
  localparam int LIMIT = (1 << W) - 1;

  logic         clk;
  logic         reset_n;
  logic         upcount;
  logic         enable;
  logic [W-1:0] out_wrap;
  logic [W-1:0] out_sat;

  int checks;
  int errors;
  int wrap_model;
  int sat_model;

  up_down_counter #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk    (clk),
    .reset_n(reset_n),
    .upcount(upcount),
    .enable (enable),
    .out    (out_wrap)
  );

  up_down_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk    (clk),
    .reset_n(reset_n),
    .upcount(upcount),
    .enable (enable),
    .out    (out_sat)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unknown control values while counting are outside the supported use.
  always @(posedge clk) begin
    if (enable !== 1'b0) begin
      assert (!$isunknown(enable) && !$isunknown(upcount))
      else $error("[TB] FAIL xcheck enable=%b upcount=%b", enable, upcount);
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference rules for one edge, written as plain integer arithmetic.
  task automatic stepModel(input bit r, input bit e, input bit u);
    if (r) begin
      wrap_model = 0;
      sat_model  = 0;
    end else if (e && u) begin
      wrap_model = (wrap_model + 1) % (LIMIT + 1);
      sat_model  = (sat_model >= LIMIT) ? LIMIT : sat_model + 1;
    end else if (e) begin
      wrap_model = (wrap_model + LIMIT) % (LIMIT + 1);
      sat_model  = (sat_model <= 0) ? 0 : sat_model - 1;
    end
  endtask

  // Compare both instances against the model.
  task automatic checkOutput(input string tag);
    logic [W-1:0] exp_wrap;
    logic [W-1:0] exp_sat;
    exp_wrap = W'(wrap_model);
    exp_sat  = W'(sat_model);
    checks++;
    assert (out_wrap === exp_wrap)
    else begin
      errors++;
      $display("[TB] FAIL %s wrap observed=%0d expected=%0d", tag, out_wrap, exp_wrap);
      $error("[TB] %s wrap", tag);
    end
    checks++;
    assert (out_sat === exp_sat)
    else begin
      errors++;
      $display("[TB] FAIL %s sat observed=%0d expected=%0d", tag, out_sat, exp_sat);
      $error("[TB] %s sat", tag);
    end
  endtask

  // Drive inputs away from the edge, clock once, then check just after.
  task automatic applyStimulus(input bit r, input bit e, input bit u, input string tag);
    @(negedge clk);
    reset_n = r;
    enable  = e;
    upcount = u;
    @(posedge clk);
    #1;
    stepModel(r, e, u);
    checkOutput(tag);
  endtask

  // Wiggle inputs mid-cycle and confirm the outputs do not move.
  task automatic glitchCheck(input string tag);
    for (int i = 0; i < 3; i++) begin
      enable  = ~enable;
      upcount = ~upcount;
      #1;
      checkOutput(tag);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    wrap_model = 0;
    sat_model  = 0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    upcount    = 1'b0;

    // Reset for two edges, then count up five.
    applyStimulus(1, 0, 0, "reset1");
    applyStimulus(1, 0, 0, "reset2");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, "count_up");

    // Hold two edges, then resume.
    applyStimulus(0, 0, 1, "hold1");
    applyStimulus(0, 0, 0, "hold2");
    applyStimulus(0, 1, 1, "resume");

    // Climb to the top, then wrap (wrap) / pin (sat).
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 1, "climb");
    applyStimulus(0, 1, 1, "top_edge");
    applyStimulus(0, 1, 1, "past_top");
    applyStimulus(0, 1, 1, "to_two");

    // Direction change without a dead cycle, wrapping below zero.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, "count_down");

    // Saturate at zero: from 1, step down three times.
    applyStimulus(1, 0, 0, "reset_lo");
    applyStimulus(0, 1, 1, "to_one");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, "floor");

    // Saturate at top: from 14, step up twice.
    applyStimulus(1, 0, 0, "reset_hi");
    for (int i = 0; i < 14; i++) applyStimulus(0, 1, 1, "to_14");
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, "ceiling");

    // Reset in the middle of a down count at 9, then resume downward.
    applyStimulus(1, 0, 0, "reset_mid");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, "to_10");
    applyStimulus(0, 1, 0, "at_9");
    applyStimulus(1, 1, 0, "reset_wins_down");
    applyStimulus(0, 1, 0, "after_reset1");
    applyStimulus(0, 1, 0, "after_reset2");

    // Reset together with an up-count request.
    applyStimulus(0, 1, 1, "pre_simul");
    applyStimulus(1, 1, 1, "reset_wins_up");

    // Outputs only change on rising edges.
    applyStimulus(0, 1, 1, "pre_glitch");
    glitchCheck("between_edges");

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), $urandom_range(0, 1) != 0,
                    $urandom_range(0, 1) != 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
